data_component_fifo: RTL and testbench

- Parametrised successor to the single-channel struct data component.
- CH independent input channels, each buffered in its own DEPTH-entry FIFO, merged by a round-robin arbiter into one registered output with valid/ready handshake.
- Mode control adds hold, flush and an LFSR randomisation mode. Randomisation XORs the output payload with a pseudo-random word.
- Sits between data producers and a single downstream consumer in the data path.

---
 rtl/dc_pkg.sv | 34 +++
 rtl/data_component_fifo_if.sv | 25 ++
 rtl/dc_chan_fifo.sv | 49 ++++
 rtl/data_component_fifo.sv | 105 ++++++++++
 tb/tb_data_component_fifo.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/dc_pkg.sv
// rtl/dc_pkg.sv - shared types, default constants and round-robin helper for data_component_fifo
package dc_pkg;

    typedef enum logic [1:0] {
        PASS  = 2'd0,
        HOLD  = 2'd1,
        RAND  = 2'd2,
        FLUSH = 2'd3
    } mode_e;

    localparam logic [31:0] DC_LFSR_SEED = 32'hACE1_0001;
    localparam logic [31:0] DC_LFSR_TAPS = 32'h8020_0003;

    // First requester strictly after ptr, wrapping within n channels (n <= 8).
    function automatic logic [2:0] rr_grant(input logic [7:0] req, input logic [2:0] ptr, input int n);
        logic [2:0] result;
        logic       found;
        int         idx;
        result = ptr;
        found  = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            if (k <= n && !found) begin
                idx = int'(ptr) + k;
                if (idx >= n) idx = idx - n;
                if (req[idx]) begin
                    result = 3'(idx);
                    found  = 1'b1;
                end
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/data_component_fifo_if.sv
// rtl/data_component_fifo_if.sv - producer/consumer handshake bundle for data_component_fifo
interface data_component_fifo_if #(
    parameter int CH     = 2,
    parameter int DATA_W = 32
);
    localparam int CHW = (CH > 1) ? $clog2(CH) : 1;

    logic [CH-1:0]        in_valid;
    logic [CH-1:0]        in_ready;
    logic [CH*DATA_W-1:0] in_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [DATA_W-1:0]    out_data;
    logic [CHW-1:0]       out_ch;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_ch
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_ch
    );
endinterface

// File: rtl/dc_chan_fifo.sv
// rtl/dc_chan_fifo.sv - single-channel synchronous FIFO with flush and occupancy output
module dc_chan_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [DATA_W-1:0]        wrData,
    output logic [DATA_W-1:0]        rdData,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   fill
);
    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wrPtr;
    logic [AW-1:0]     rdPtr;
    logic [AW:0]       count;

    assign full   = (count == (AW+1)'(DEPTH));
    assign empty  = (count == '0);
    assign rdData = mem[rdPtr];
    assign fill   = count;

    // Storage carries no reset; validity is tracked by count alone.
    always_ff @(posedge clk) begin
        if (push) mem[wrPtr] <= wrData;
    end

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (push) wrPtr <= wrPtr + AW'(1);
            if (pop)  rdPtr <= rdPtr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/data_component_fifo.sv
// rtl/data_component_fifo.sv - CH buffered input channels merged round-robin into one registered output
module data_component_fifo
    import dc_pkg::*;
#(
    parameter int          DATA_W    = 32,
    parameter int          DEPTH     = 4,
    parameter int          CH        = 2,
    parameter bit          RND_EN    = 1'b1,
    parameter logic [31:0] LFSR_SEED = DC_LFSR_SEED,
    parameter logic [31:0] LFSR_TAPS = DC_LFSR_TAPS
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [1:0]                          ctrl_mode,
    data_component_fifo_if.slave                bus,
    output logic [CH*($clog2(DEPTH)+1)-1:0]     fill
);
    localparam int FW  = $clog2(DEPTH) + 1;
    localparam int CHW = (CH > 1) ? $clog2(CH) : 1;
    localparam logic [DATA_W-1:0] SEED_TRUNC = LFSR_SEED[DATA_W-1:0];
    localparam logic [DATA_W-1:0] SEED = (SEED_TRUNC == '0) ? DATA_W'(1) : SEED_TRUNC;
    localparam logic [DATA_W-1:0] TAPS = LFSR_TAPS[DATA_W-1:0];

    typedef struct packed {
        logic [DATA_W-1:0] rand_val;
    } data_t;

    mode_e             mode;
    logic              runMode;
    logic              doRand;
    logic [CH-1:0]     full;
    logic [CH-1:0]     empty;
    logic [CH-1:0]     push;
    logic [CH-1:0]     pop;
    logic [DATA_W-1:0] headData [CH];
    logic [2:0]        grantRaw;
    logic [CHW-1:0]    grant;
    logic [CHW-1:0]    rrPtr;
    logic              load;
    data_t             loadData;
    data_t             outReg;
    logic [CHW-1:0]    outCh;
    logic              outValid;
    logic [DATA_W-1:0] lfsr;
    logic [DATA_W-1:0] lfsrNext;

    assign mode    = mode_e'(ctrl_mode);
    assign runMode = (mode == PASS) || (mode == RAND);
    assign doRand  = RND_EN && (mode == RAND);

    assign bus.in_ready = rst_n ? (~full & {CH{runMode}}) : '0;
    assign push         = bus.in_valid & bus.in_ready;

    generate
        for (genvar c = 0; c < CH; c++) begin : gChan
            dc_chan_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) uFifo (
                .clk    (clk),
                .rst_n  (rst_n),
                .flush  (mode == FLUSH),
                .push   (push[c]),
                .pop    (pop[c]),
                .wrData (bus.in_data[c*DATA_W +: DATA_W]),
                .rdData (headData[c]),
                .full   (full[c]),
                .empty  (empty[c]),
                .fill   (fill[c*FW +: FW])
            );
        end
    endgenerate

    assign grantRaw = rr_grant(8'(~empty), 3'(rrPtr), CH);
    assign grant    = grantRaw[CHW-1:0];
    assign load     = runMode && (!outValid || bus.out_ready) && (|(~empty));
    assign pop      = load ? (CH'(1) << grant) : '0;

    // Galois step: shift right, fold the taps back in when a one drops out.
    assign lfsrNext          = (lfsr >> 1) ^ (lfsr[0] ? TAPS : '0);
    assign loadData.rand_val = headData[grant] ^ (doRand ? lfsr : '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            outValid <= 1'b0;
            outReg   <= '0;
            outCh    <= '0;
            rrPtr    <= CHW'(CH - 1);
            lfsr     <= SEED;
        end else if (mode == FLUSH) begin
            outValid <= 1'b0;
        end else if (runMode) begin
            if (load) begin
                outValid <= 1'b1;
                outReg   <= loadData;
                outCh    <= grant;
                rrPtr    <= grant;
                if (doRand) lfsr <= lfsrNext;
            end else if (bus.out_ready) begin
                outValid <= 1'b0;
            end
        end
    end

    assign bus.out_valid = outValid;
    assign bus.out_data  = outReg.rand_val;
    assign bus.out_ch    = outCh;
endmodule

// File: tb/tb_data_component_fifo.sv
// tb/tb_data_component_fifo.sv - scoreboard bench for data_component_fifo
module tb_data_component_fifo;
    logic       clk;
    logic       rst_n;
    logic [1:0] ctrl_mode;
    logic [5:0] fill;

    data_component_fifo_if #(.CH(2), .DATA_W(32)) ifc ();

    data_component_fifo #(
        .DATA_W(32), .DEPTH(4), .CH(2), .RND_EN(1'b1),
        .LFSR_SEED(32'h0000_0001), .LFSR_TAPS(32'h8020_0003)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ctrl_mode (ctrl_mode),
        .bus       (ifc.slave),
        .fill      (fill)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] d;
        logic        c;
    } exp_t;

    exp_t expQ [$];
    int   nChecks = 0;
    int   nFails  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] d, input logic c);
        exp_t e;
        e.d = d;
        e.c = c;
        return e;
    endfunction

    // Monitor: a transfer happens only when the block runs (PASS/RAND) and both sides agree.
    always @(negedge clk) begin
        if (rst_n && (ctrl_mode == 2'd0 || ctrl_mode == 2'd2) && ifc.out_valid && ifc.out_ready) begin
            if (expQ.size() == 0) begin
                check("unexpected_output", {31'd0, ifc.out_valid}, 64'd0);
            end else begin
                exp_t e;
                e = expQ.pop_front();
                check("out_data", {32'd0, ifc.out_data}, {32'd0, e.d});
                check("out_ch", {63'd0, ifc.out_ch}, {63'd0, e.c});
            end
        end
    end

    task automatic pushTwo(input logic [1:0] m, input logic [31:0] d0, input logic [31:0] d1);
        int n;
        n = 0;
        if (m[0]) begin ifc.in_valid[0] = 1'b1; ifc.in_data[31:0]  = d0; end
        if (m[1]) begin ifc.in_valid[1] = 1'b1; ifc.in_data[63:32] = d1; end
        @(negedge clk);
        while (((ifc.in_ready & m) != m) && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (n >= 50) check("push_timeout", 64'(n), 64'd0);
        @(posedge clk);
        #1;
        ifc.in_valid = 2'b00;
    endtask

    task automatic waitDrain();
        int n;
        n = 0;
        while (expQ.size() != 0 && n < 60) begin
            n++;
            @(posedge clk);
        end
        #1;
        check("drain_queue_empty", 64'(expQ.size()), 64'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        ifc.in_valid = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n         = 1'b0;
        ctrl_mode     = 2'd0;
        ifc.in_valid  = 2'b00;
        ifc.in_data   = '0;
        ifc.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_in_ready", 64'(ifc.in_ready), 64'd0);
        check("reset_out_valid", 64'(ifc.out_valid), 64'd0);
        check("reset_out_data", 64'(ifc.out_data), 64'd0);
        check("reset_out_ch", 64'(ifc.out_ch), 64'd0);
        check("reset_fill", 64'(fill), 64'd0);
        rst_n = 1'b1;

        // Single word latency
        ifc.out_ready = 1'b1;
        expQ.push_back(mk(32'h11, 1'b0));
        pushTwo(2'b01, 32'h11, 32'h0);
        check("lat_valid_early", 64'(ifc.out_valid), 64'd0);
        check("lat_fill_after_push", 64'(fill[2:0]), 64'd1);
        @(posedge clk);
        #1;
        check("lat_valid", 64'(ifc.out_valid), 64'd1);
        check("lat_data", 64'(ifc.out_data), 64'h11);
        check("lat_ch", 64'(ifc.out_ch), 64'd0);
        check("lat_fill_drained", 64'(fill[2:0]), 64'd0);
        waitDrain();

        // Two-channel interleave
        doReset();
        ifc.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            expQ.push_back(mk(32'hA000_0000 + 32'(i), 1'b0));
            expQ.push_back(mk(32'hB000_0000 + 32'(i), 1'b1));
        end
        for (int i = 0; i < 3; i++) pushTwo(2'b11, 32'hA000_0000 + 32'(i), 32'hB000_0000 + 32'(i));
        waitDrain();

        // Backpressure and full FIFO
        doReset();
        ifc.out_ready = 1'b0;
        for (int i = 0; i < 6; i++) expQ.push_back(mk(32'hC000_0000 + 32'(i), 1'b0));
        for (int i = 0; i < 5; i++) pushTwo(2'b01, 32'hC000_0000 + 32'(i), 32'h0);
        ifc.in_valid[0] = 1'b1;
        ifc.in_data[31:0] = 32'hC000_0005;
        @(negedge clk);
        check("full_in_ready0", 64'(ifc.in_ready[0]), 64'd0);
        check("full_fill0", 64'(fill[2:0]), 64'd4);
        check("full_out_data", 64'(ifc.out_data), 64'hC000_0000);
        ifc.out_ready = 1'b1;
        pushTwo(2'b01, 32'hC000_0005, 32'h0);
        waitDrain();

        // LFSR randomisation
        doReset();
        ctrl_mode = 2'd2;
        ifc.out_ready = 1'b1;
        expQ.push_back(mk(32'h0000_0001, 1'b0));
        expQ.push_back(mk(32'h8020_0003, 1'b0));
        pushTwo(2'b01, 32'h0, 32'h0);
        pushTwo(2'b01, 32'h0, 32'h0);
        waitDrain();
        ctrl_mode = 2'd0;

        // HOLD freezes everything, FLUSH empties
        doReset();
        ifc.out_ready = 1'b0;
        pushTwo(2'b01, 32'h5A5A_5A5A, 32'h0);
        pushTwo(2'b10, 32'h0, 32'h3C3C_3C3C);
        ctrl_mode = 2'd1;
        for (int i = 0; i < 5; i++) begin
            ifc.out_ready = i[0];
            @(negedge clk);
            check("hold_out_valid", 64'(ifc.out_valid), 64'd1);
            check("hold_out_data", 64'(ifc.out_data), 64'h5A5A_5A5A);
            check("hold_in_ready", 64'(ifc.in_ready), 64'd0);
            @(posedge clk);
            #1;
        end
        check("hold_fill1", 64'(fill[5:3]), 64'd1);
        ctrl_mode = 2'd3;
        @(negedge clk);
        check("flush_in_ready", 64'(ifc.in_ready), 64'd0);
        @(posedge clk);
        #1;
        check("flush_out_valid", 64'(ifc.out_valid), 64'd0);
        check("flush_fill", 64'(fill), 64'd0);
        ctrl_mode = 2'd0;
        ifc.out_ready = 1'b0;

        // Mid-operation reset, then channel 0 wins first
        pushTwo(2'b10, 32'h0, 32'h61);
        pushTwo(2'b10, 32'h0, 32'h62);
        pushTwo(2'b10, 32'h0, 32'h63);
        pushTwo(2'b01, 32'h64, 32'h0);
        pushTwo(2'b01, 32'h65, 32'h0);
        check("pre_reset_fill", 64'(fill), 64'h12);
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_in_ready", 64'(ifc.in_ready), 64'd0);
        @(posedge clk);
        #1;
        check("rst_fill", 64'(fill), 64'd0);
        check("rst_out_valid", 64'(ifc.out_valid), 64'd0);
        rst_n = 1'b1;
        ifc.out_ready = 1'b1;
        expQ.push_back(mk(32'h71, 1'b0));
        expQ.push_back(mk(32'h72, 1'b1));
        pushTwo(2'b11, 32'h71, 32'h72);
        waitDrain();

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end
endmodule
